hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core. It drives the stall and flush controls of the F/D, D/E, E/M and M/W pipeline registers, and generates the E-stage forwarding selects. It adds a sequential data-memory miss sequencer that freezes the whole pipe for a bounded number of cycles. A redirect that arrives during a freeze is deferred and replayed when the freeze ends.

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding selects, load-use stall, branch flush
// and a data-miss freeze sequencer. Define HAZARD_STATS_EN to add saturating event counters.
module hazard_ctrl #(
    parameter int MISS_LAT = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1D,
    input  logic [4:0] rs2D,
    input  logic [4:0] rs1E,
    input  logic [4:0] rs2E,
    input  logic [4:0] rdE,
    input  logic       loadE,
    input  logic       pcsrcE,
    input  logic       regwriteM,
    input  logic [4:0] rdM,
    input  logic       regwriteW,
    input  logic [4:0] rdW,
    input  logic       dmissM,
    output logic       stallF,
    output logic       stallD,
    output logic       flushD,
    output logic       flushE,
    output logic       freeze,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stat_lw,
    output logic [31:0] stat_flush,
    output logic [31:0] stat_miss,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESUME = 2'd2} state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MISS_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pend_flush, pend_nxt;
    logic             lwstall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (regwriteM && rdM != 5'd0 && rdM == rs)      fwd_sel = 2'b10;
        else if (regwriteW && rdW != 5'd0 && rdW == rs) fwd_sel = 2'b01;
        else                                            fwd_sel = 2'b00;
    endfunction

    assign forwardAE = fwd_sel(rs1E);
    assign forwardBE = fwd_sel(rs2E);
    assign lwstall   = loadE && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend_flush;
        stallF    = 1'b0;
        stallD    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        freeze    = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (dmissM) begin
                    state_nxt = (MISS_LAT == 1) ? RESUME : WAIT;
                    cnt_nxt   = CNT_INIT;
                    pend_nxt  = pcsrcE;
                    freeze    = 1'b1;
                    stallF    = 1'b1;
                    stallD    = 1'b1;
                    busy      = 1'b1;
                end else begin
                    stallF = lwstall;
                    stallD = lwstall;
                    flushD = pcsrcE;
                    flushE = lwstall | pcsrcE;
                end
            end
            WAIT: begin
                freeze  = 1'b1;
                stallF  = 1'b1;
                stallD  = 1'b1;
                busy    = 1'b1;
                cnt_nxt = cnt - CNT_ONE;
                // leave as the countdown reaches zero, so WAIT spans MISS_LAT-1 cycles
                if (cnt <= CNT_ONE) state_nxt = RESUME;
            end
            RESUME: begin
                busy      = 1'b1;
                stallF    = lwstall;
                stallD    = lwstall;
                flushD    = pend_flush | pcsrcE;
                flushE    = pend_flush | pcsrcE | lwstall;
                pend_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            stallF = 1'b0;
            stallD = 1'b0;
            flushD = 1'b0;
            flushE = 1'b0;
            freeze = 1'b0;
            busy   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pend_flush <= pend_nxt;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lw    <= '0;
            stat_flush <= '0;
            stat_miss  <= '0;
        end else begin
            // a load-use stall only counts when it is not hidden under a freeze
            if (lwstall && !freeze && stat_lw != '1) stat_lw <= stat_lw + 32'd1;
            if (flushD && stat_flush != '1)          stat_flush <= stat_flush + 32'd1;
            if (freeze && stat_miss != '1)           stat_miss <= stat_miss + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MISS_LAT=4).
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       loadE, pcsrcE, regwriteM, regwriteW, dmissM;
    logic       stallF, stallD, flushD, flushE, freeze, busy;
    logic [1:0] forwardAE, forwardBE;
`ifdef HAZARD_STATS_EN
    logic [31:0] stat_lw, stat_flush, stat_miss;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    hazard_ctrl #(.MISS_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .loadE(loadE), .pcsrcE(pcsrcE),
        .regwriteM(regwriteM), .rdM(rdM), .regwriteW(regwriteW), .rdW(rdW),
        .dmissM(dmissM),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .freeze(freeze), .forwardAE(forwardAE), .forwardBE(forwardBE),
`ifdef HAZARD_STATS_EN
        .stat_lw(stat_lw), .stat_flush(stat_flush), .stat_miss(stat_miss),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ctrl = {freeze, busy, stallF, stallD, flushD, flushE}
    task automatic chk_ctrl(input string tag, input logic [5:0] exp);
        #1;
        chk(tag, {26'd0, freeze, busy, stallF, stallD, flushD, flushE}, {26'd0, exp});
    endtask

    task automatic idle_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        loadE = 0; pcsrcE = 0; regwriteM = 0; regwriteW = 0; dmissM = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        // reset masks hazards but forwarding stays live
        loadE = 1; rdE = 7; rs2D = 7; pcsrcE = 1;
        regwriteM = 1; rdM = 5; rs1E = 5;
        chk_ctrl("reset_ctrl", 6'b000000);
        chk("reset_fwdA", {30'd0, forwardAE}, 32'd2);
        step(); step();
        idle_inputs();
        rst = 1'b0;

        // forwarding priority and x0 exclusion
        regwriteM = 1; rdM = 5; rs1E = 5; regwriteW = 1; rdW = 5; rs2E = 5;
        #1;
        chk("fwdA_M", {30'd0, forwardAE}, 32'd2);
        rdM = 6;
        #1;
        chk("fwdA_W", {30'd0, forwardAE}, 32'd1);
        chk("fwdB_W", {30'd0, forwardBE}, 32'd1);
        rdM = 0; rs1E = 0; rdW = 0;
        #1;
        chk("fwdA_x0", {30'd0, forwardAE}, 32'd0);
        idle_inputs();

        // load-use stall, then rdE=0 gives no stall
        step();
        loadE = 1; rdE = 7; rs2D = 7;
        chk_ctrl("lw_stall", 6'b001101);
        rdE = 0;
        chk_ctrl("lw_x0", 6'b000000);
        idle_inputs();

        // taken branch without a miss
        step();
        pcsrcE = 1;
        chk_ctrl("branch", 6'b000011);
        idle_inputs();

        // plain miss: frozen t..t+3, resume t+4, idle t+5
        step();
        dmissM = 1;
        chk_ctrl("miss_t0", 6'b111100);
        for (int i = 1; i <= 3; i++) begin
            step();
            dmissM = 0;
            chk_ctrl($sformatf("miss_t%0d", i), 6'b111100);
        end
        step();
        chk_ctrl("miss_resume", 6'b010000);
        step();
        chk_ctrl("miss_idle", 6'b000000);

        // miss with simultaneous redirect: flush deferred to resume
        dmissM = 1; pcsrcE = 1;
        chk_ctrl("dfr_t0", 6'b111100);
        for (int i = 1; i <= 3; i++) begin
            step();
            dmissM = 0; pcsrcE = 0;
            chk_ctrl($sformatf("dfr_t%0d", i), 6'b111100);
        end
        step();
        chk_ctrl("dfr_resume", 6'b010011);
        // back-to-back: miss ignored during resume, honoured from idle
        dmissM = 1;
        chk_ctrl("b2b_resume", 6'b010011);
        step();
        chk_ctrl("b2b_entry", 6'b111100);
        step();
        dmissM = 0;
        chk_ctrl("b2b_wait_cnt3", 6'b111100);
        step();
        // async reset mid-WAIT at cnt=2
        rst = 1'b1;
        chk_ctrl("rst_midwait", 6'b000000);
        step();
        rst = 1'b0;
        chk_ctrl("post_rst_idle", 6'b000000);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_ctrl($sformatf("post_rst_no_pend%0d", i), 6'b000000);
        end
        pcsrcE = 1;
        chk_ctrl("post_rst_branch", 6'b000011);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
